// File: rtl/sum_div_if.sv
// Handshake bundle between the 3-input adder stage and the sum divider.
// Valid/ready on both sides: a transfer happens on a rising clock edge where
// valid and ready are both high; a source holds valid (and its data) until that
// edge, and a sink may raise or drop ready at any time without waiting for valid.
`timescale 1ns/1ps
interface sum_div_if #(
  parameter int WIDTH   = 10,
  parameter int DIVISOR = 3
);
  localparam int RWIDTH = $clog2(DIVISOR);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  sum;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  quotient;
  logic [RWIDTH-1:0] remainder;
  logic              busy;

  // Producer of sums / consumer of results (upstream adder, downstream user)
  modport master (
    output in_valid,
    output sum,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  busy
  );

  // The divider itself
  modport slave (
    input  in_valid,
    input  sum,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output busy
  );
endinterface

// File: rtl/sum_div_seq.sv
// Sequential restoring divider: divides a WIDTH-bit sum by the constant DIVISOR,
// producing one quotient bit per clock, MSB first. With the defaults it turns
// the 10-bit sum of three 8-bit operands into their average and remainder.
// in_ready/out_valid/busy are decoded from the registered state only, so there
// is no combinational path from any input to any output.
`timescale 1ns/1ps
module sum_div_seq #(
  parameter int WIDTH   = 10,
  parameter int DIVISOR = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  sum_div_if.slave   bus,
  output logic [1:0] dbg_state
);

  localparam int RWIDTH = $clog2(DIVISOR);
  localparam int CWIDTH = $clog2(WIDTH);

  // Divisor at partial-remainder width; the shifted remainder is at most
  // 2*(DIVISOR-1)+1, which always fits in RWIDTH+1 bits.
  localparam logic [RWIDTH:0]   DIV_R    = (RWIDTH+1)'(DIVISOR);
  localparam logic [CWIDTH-1:0] CNT_LAST = CWIDTH'(WIDTH - 1);

  // Parameter sanity, caught at elaboration.
  if (WIDTH < 2 || WIDTH > 30) begin : g_bad_width
    $error("sum_div_seq: WIDTH must be in 2..30");
  end
  if (DIVISOR < 2 || DIVISOR >= (1 << WIDTH)) begin : g_bad_divisor
    $error("sum_div_seq: DIVISOR must satisfy 2 <= DIVISOR < 2**WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Dividend bits shift out at the top while quotient bits shift in at the
  // bottom, so after WIDTH iterations this register holds the quotient.
  logic [WIDTH-1:0]  shift_q;
  logic [RWIDTH:0]   rem_part_q;
  logic [CWIDTH-1:0] cnt_q;

  // Result registers: loaded on the last iteration, then held through DONE
  // and IDLE until the next result overwrites them.
  logic [WIDTH-1:0]  quot_q;
  logic [RWIDTH-1:0] rem_q;

  logic              accept;
  logic              out_fire;
  logic              last_iter;

  logic [RWIDTH:0]   r_shift;
  logic              q_bit;
  logic [RWIDTH:0]   rem_next;
  logic [WIDTH-1:0]  shift_next;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    r_shift    = (rem_part_q << 1) | {{RWIDTH{1'b0}}, shift_q[WIDTH-1]};
    q_bit      = (r_shift >= DIV_R);
    rem_next   = q_bit ? (r_shift - DIV_R) : r_shift;
    shift_next = {shift_q[WIDTH-2:0], q_bit};
  end

  // Handshake qualifiers, built only from registered state plus the
  // partner's valid/ready, and used only to update registers.
  always_comb begin
    accept    = (state_q == IDLE) && bus.in_valid;
    out_fire  = (state_q == DONE) && bus.out_ready;
    last_iter = (state_q == BUSY) && (cnt_q == '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the state-decoded handshake outputs.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        bus.busy = 1'b1;
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (out_fire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Iteration datapath: load on accept, one quotient bit per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      rem_part_q <= '0;
      cnt_q      <= '0;
    end else if (accept) begin
      shift_q    <= bus.sum;
      rem_part_q <= '0;
      cnt_q      <= CNT_LAST;
    end else if (state_q == BUSY) begin
      shift_q    <= shift_next;
      rem_part_q <= rem_next;
      cnt_q      <= cnt_q - CWIDTH'(1);
    end
  end

  // Result capture on the final iteration; untouched otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
    end else if (last_iter) begin
      quot_q <= shift_next;
      rem_q  <= rem_next[RWIDTH-1:0];
    end
  end

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign dbg_state     = state_q;

  // Embedded properties for checkers bound against this block.
  a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
    state_q inside {IDLE, BUSY, DONE});

  a_ready_busy_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.in_ready && (bus.busy || bus.out_valid)));

  a_rem_bound: assert property (@(posedge clk) disable iff (!rst_n)
    rem_part_q < DIV_R);

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.quotient) && $stable(bus.remainder)));

  a_busy_len: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE && bus.in_valid) |=> bus.busy [*WIDTH] ##1 bus.out_valid);

endmodule

// File: tb/tb_sum_div_seq.sv
// Self-checking bench for sum_div_seq: directed cases (latency, pulse width,
// backpressure, sampling of sum, reset during a division) followed by a sweep
// of every possible sum with random consumer stalls. Expected results come
// from the queued sums divided by the bench itself.
`timescale 1ns/1ps
module tb_sum_div_seq;

  localparam int W   = 10;
  localparam int DIV = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  sum_div_if #(.WIDTH(W), .DIVISOR(DIV)) bus ();

  sum_div_seq #(.WIDTH(W), .DIVISOR(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int         checks     = 0;
  int         failures   = 0;
  int         n_in       = 0;
  int         n_out      = 0;
  bit         rand_ready = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, want, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [W-1:0] s);
    int g;
    g = 0;
    while (!bus.in_ready && g < 200) begin
      tick();
      g++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.sum      = s;
    exp_q.push_back(s);
    n_in++;
    tick();
    bus.in_valid = 1'b0;
    bus.sum      = W'($urandom_range(0, 1023));
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 64) begin
      tick();
      n++;
    end
    check("out_valid_seen", bus.out_valid, 1);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("out_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_sum = exp_q.pop_front();
        check("quotient", bus.quotient, mon_sum / DIV);
        check("remainder", bus.remainder, mon_sum % DIV);
        check("identity", bus.quotient * DIV + bus.remainder, mon_sum);
        n_out++;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] seq_sums[4];
  logic [W-1:0] perm[1024];
  logic [W-1:0] tmp;
  int           lat;
  int           j;
  int           g;

  initial begin
    bus.in_valid  = 1'b0;
    bus.sum       = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy",      bus.busy, 0);
    check("rst_quotient",  bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_state",     dbg_state, 0);
    rst_n = 1'b1;
    tick();

    // 20 -> 6 r 2; sum changed to 999 while busy must not matter
    bus.out_ready = 1'b1;
    send(10'd20);
    check("busy_after_accept", bus.busy, 1);
    check("in_ready_in_busy", bus.in_ready, 0);
    bus.sum = 10'd999;
    wait_out(lat);
    check("latency_20", lat, 10);
    check("q_20", bus.quotient, 6);
    check("r_20", bus.remainder, 2);
    tick();
    check("pulse_width", bus.out_valid, 0);
    check("in_ready_after_hs", bus.in_ready, 1);

    // Back-to-back boundary and typical values
    seq_sums[0] = 10'd218;
    seq_sums[1] = 10'd1023;
    seq_sums[2] = 10'd0;
    seq_sums[3] = 10'd2;
    for (int i = 0; i < 4; i++) begin
      send(seq_sums[i]);
      wait_out(lat);
      check("latency_seq", lat, 10);
      tick();
    end

    // Backpressure: result held, in_ready low, extra in_valid ignored
    bus.out_ready = 1'b0;
    send(10'd100);
    wait_out(lat);
    for (int k = 0; k < 5; k++) begin
      check("bp_quotient",  bus.quotient, 33);
      check("bp_remainder", bus.remainder, 1);
      check("bp_valid",     bus.out_valid, 1);
      check("bp_in_ready",  bus.in_ready, 0);
      if (k == 1) begin
        bus.in_valid = 1'b1;
        bus.sum      = 10'd50;
      end
      if (k == 2) bus.in_valid = 1'b0;
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_valid_drop", bus.out_valid, 0);
    check("bp_in_ready_rise", bus.in_ready, 1);
    repeat (15) tick();
    check("bp_ignored_idle", dbg_state, 0);
    check("bp_ignored_busy", bus.busy, 0);

    // Reset in the 4th BUSY cycle abandons the division
    send(10'd20);
    repeat (3) tick();
    check("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready",  bus.in_ready, 1);
    check("mid_rst_busy",      bus.busy, 0);
    check("mid_rst_state",     dbg_state, 0);
    check("mid_rst_quotient",  bus.quotient, 0);
    exp_q.delete();
    n_in--;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_out_valid", bus.out_valid, 0);
    send(10'd9);
    wait_out(lat);
    check("latency_9", lat, 10);
    check("q_9", bus.quotient, 3);
    check("r_9", bus.remainder, 0);
    tick();

    // Every sum once, shuffled, with random out_ready stalls
    for (int i = 0; i < 1024; i++) perm[i] = W'(i);
    for (int i = 1023; i > 0; i--) begin
      j       = $urandom_range(0, i);
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    rand_ready = 1'b1;
    for (int i = 0; i < 1024; i++) send(perm[i]);
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      tick();
      g++;
    end
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) tick();
    check("drain_empty", exp_q.size(), 0);
    check("in_out_count", n_out, n_in);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
